// File: rtl/dac_stream_pkg.sv
// Shared definitions for the SPI DAC streaming engine: FSM states, MCP49x2
// command-word bit positions and the frame-length helper.
package dac_stream_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        LDAC     = 3'd4
    } dac_state_e;

    localparam int WORD_W      = 16;
    localparam int DAC_FIELD_W = 12;
    localparam int AB_BIT      = 15;
    localparam int BUF_BIT     = 14;
    localparam int GA_BIT      = 13;
    localparam int SHDN_BIT    = 12;

    // Cycles busy stays high for one complete frame.
    function automatic int frame_cyc(input int nch, input int sck_half);
        return nch * 34 * sck_half + sck_half;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-rate tick generator: one-cycle pulse every DIV clocks while enabled.
module tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int            CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running modulo-DIV counter, held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!enable) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/spi_dac_stream.sv
// SPI DAC streaming engine: buffers one multi-channel sample, and on each
// sample tick serialises one command word per channel followed by an LDAC pulse.
module spi_dac_stream
    import dac_stream_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int NCH        = 2,
    parameter int SAMPLE_DIV = 5000,
    parameter int SCK_HALF   = 2,
    parameter int GAIN_1X    = 1,
    parameter int BUF_REF    = 0
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NCH*DATA_W-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  dac_cs,
    output logic                  dac_sck,
    output logic                  dac_sdi,
    output logic                  dac_ld,
    output logic                  busy,
    output logic                  underrun,
    output logic                  overrun,
    input  logic                  clr_flags
);

    localparam int                HALF_W    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);

    function automatic logic [DATA_W-1:0] chan_sample(input logic [NCH*DATA_W-1:0] vec,
                                                      input logic [0:0] ch);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int k = 0; k < NCH; k++) begin
            if (k == int'(ch)) s = vec[k*DATA_W +: DATA_W];
        end
        return s;
    endfunction

    // Sample is left-justified into the 12-bit DAC field; SHDN_n is always 1.
    function automatic logic [WORD_W-1:0] build_word(input logic [DATA_W-1:0] sample,
                                                     input logic [0:0] ch);
        logic [WORD_W-1:0] w;
        w                          = '0;
        w[AB_BIT]                  = ch[0];
        w[BUF_BIT]                 = (BUF_REF != 0);
        w[GA_BIT]                  = (GAIN_1X != 0);
        w[SHDN_BIT]                = 1'b1;
        w[DAC_FIELD_W-1 -: DATA_W] = sample;
        return w;
    endfunction

    logic                  tick_s;
    logic                  load_s;
    logic                  accept_s;
    logic                  take_s;
    logic [NCH*DATA_W-1:0] sample_sel_s;
    logic [WORD_W-1:0]     first_word_s;
    logic [WORD_W-1:0]     next_word_s;
    logic                  more_ch_s;
    logic                  half_end_s;

    logic [NCH*DATA_W-1:0] hold_r;
    logic                  ready_r;
    logic [NCH*DATA_W-1:0] shadow_r;
    logic                  underrun_r;
    logic                  overrun_r;

    dac_state_e            state_r,  state_nxt_s;
    logic [HALF_W-1:0]     half_r,   half_nxt_s;
    logic [3:0]            bit_r,    bit_nxt_s;
    logic [0:0]            ch_r,     ch_nxt_s;
    logic [WORD_W-1:0]     shift_r,  shift_nxt_s;
    logic                  cs_r,     cs_nxt_s;
    logic                  sck_r,    sck_nxt_s;
    logic                  sdi_r,    sdi_nxt_s;
    logic                  ld_r,     ld_nxt_s;
    logic                  busy_r;

    tick_gen #(.DIV(SAMPLE_DIV)) u_tick_gen (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick_s)
    );

    // A same-cycle load counts as a full holding register for the tick.
    assign load_s       = data_valid && ready_r;
    assign accept_s     = tick_s && !busy_r;
    assign take_s       = accept_s && (!ready_r || load_s);
    assign sample_sel_s = ready_r ? data_in : hold_r;
    assign first_word_s = build_word(chan_sample(take_s ? sample_sel_s : shadow_r, 1'b0), 1'b0);
    assign next_word_s  = build_word(chan_sample(shadow_r, ch_r + 1'b1), ch_r + 1'b1);
    assign more_ch_s    = (int'(ch_r) < NCH - 1);
    assign half_end_s   = (half_r == HALF_LAST);

    // Holding and shadow sample registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r   <= '0;
            ready_r  <= 1'b1;
            shadow_r <= '0;
        end else begin
            if (load_s) hold_r <= data_in;
            if (take_s) begin
                ready_r  <= 1'b1;
                shadow_r <= sample_sel_s;
            end else if (load_s) begin
                ready_r  <= 1'b0;
            end
        end
    end

    // Sticky status flags; a set wins over a same-cycle clear.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (accept_s && !take_s) underrun_r <= 1'b1;
            else if (clr_flags)      underrun_r <= 1'b0;
            if (tick_s && busy_r)    overrun_r  <= 1'b1;
            else if (clr_flags)      overrun_r  <= 1'b0;
        end
    end

    // Frame sequencer next state; pin values are computed for the next state.
    always_comb begin
        state_nxt_s = state_r;
        half_nxt_s  = half_r;
        bit_nxt_s   = bit_r;
        ch_nxt_s    = ch_r;
        shift_nxt_s = shift_r;
        cs_nxt_s    = cs_r;
        sck_nxt_s   = sck_r;
        sdi_nxt_s   = sdi_r;
        ld_nxt_s    = ld_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = CS_SETUP;
                    half_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                    ch_nxt_s    = 1'b0;
                    shift_nxt_s = first_word_s;
                    cs_nxt_s    = 1'b0;
                    sck_nxt_s   = 1'b0;
                    sdi_nxt_s   = first_word_s[WORD_W-1];
                end else begin
                    half_nxt_s  = '0;
                end
            end
            CS_SETUP: begin
                if (half_end_s) begin
                    state_nxt_s = SHIFT;
                    half_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                    sck_nxt_s   = 1'b1;
                end else begin
                    half_nxt_s  = half_r + 1'b1;
                end
            end
            SHIFT: begin
                if (half_end_s) begin
                    half_nxt_s = '0;
                    if (sck_r) begin
                        sck_nxt_s   = 1'b0;
                        shift_nxt_s = {shift_r[WORD_W-2:0], 1'b0};
                        sdi_nxt_s   = shift_r[WORD_W-2];
                    end else if (bit_r == 4'd15) begin
                        state_nxt_s = CS_HOLD;
                        cs_nxt_s    = 1'b1;
                        sdi_nxt_s   = 1'b0;
                    end else begin
                        bit_nxt_s   = bit_r + 4'd1;
                        sck_nxt_s   = 1'b1;
                    end
                end else begin
                    half_nxt_s = half_r + 1'b1;
                end
            end
            CS_HOLD: begin
                if (half_end_s) begin
                    half_nxt_s = '0;
                    if (more_ch_s) begin
                        state_nxt_s = CS_SETUP;
                        ch_nxt_s    = ch_r + 1'b1;
                        shift_nxt_s = next_word_s;
                        cs_nxt_s    = 1'b0;
                        sdi_nxt_s   = next_word_s[WORD_W-1];
                    end else begin
                        state_nxt_s = LDAC;
                        ld_nxt_s    = 1'b0;
                    end
                end else begin
                    half_nxt_s = half_r + 1'b1;
                end
            end
            LDAC: begin
                if (half_end_s) begin
                    state_nxt_s = IDLE;
                    half_nxt_s  = '0;
                    ld_nxt_s    = 1'b1;
                end else begin
                    half_nxt_s  = half_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                half_nxt_s  = '0;
                bit_nxt_s   = 4'd0;
                ch_nxt_s    = 1'b0;
                shift_nxt_s = '0;
                cs_nxt_s    = 1'b1;
                sck_nxt_s   = 1'b0;
                sdi_nxt_s   = 1'b0;
                ld_nxt_s    = 1'b1;
            end
        endcase
    end

    // Frame sequencer state, counters and registered pin drivers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            half_r  <= '0;
            bit_r   <= 4'd0;
            ch_r    <= 1'b0;
            shift_r <= '0;
            cs_r    <= 1'b1;
            sck_r   <= 1'b0;
            sdi_r   <= 1'b0;
            ld_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            half_r  <= half_nxt_s;
            bit_r   <= bit_nxt_s;
            ch_r    <= ch_nxt_s;
            shift_r <= shift_nxt_s;
            cs_r    <= cs_nxt_s;
            sck_r   <= sck_nxt_s;
            sdi_r   <= sdi_nxt_s;
            ld_r    <= ld_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign data_ready = ready_r;
    assign dac_cs     = cs_r;
    assign dac_sck    = sck_r;
    assign dac_sdi    = sdi_r;
    assign dac_ld     = ld_r;
    assign busy       = busy_r;
    assign underrun   = underrun_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_spi_dac_stream.sv
// Directed bench for spi_dac_stream: default build, a short-period build that
// overruns, and a 12-bit single-channel build with a one-cycle SCK half period.
module tb_spi_dac_stream;

    logic        sysclk;
    logic        rstn  [3];
    logic        en    [3];
    logic        valid [3];
    logic        clr   [3];
    logic [19:0] d0;
    logic [19:0] d1;
    logic [11:0] d2;

    logic cs_w [3], sck_w [3], sdi_w [3], ld_w [3];
    logic busy_w [3], ready_w [3], und_w [3], ovr_w [3];

    int errors = 0;
    int checks = 0;

    spi_dac_stream u0 (
        .sysclk(sysclk), .rst_n(rstn[0]), .enable(en[0]), .data_in(d0), .data_valid(valid[0]),
        .data_ready(ready_w[0]), .dac_cs(cs_w[0]), .dac_sck(sck_w[0]), .dac_sdi(sdi_w[0]),
        .dac_ld(ld_w[0]), .busy(busy_w[0]), .underrun(und_w[0]), .overrun(ovr_w[0]),
        .clr_flags(clr[0]));

    spi_dac_stream #(.SAMPLE_DIV(100)) u1 (
        .sysclk(sysclk), .rst_n(rstn[1]), .enable(en[1]), .data_in(d1), .data_valid(valid[1]),
        .data_ready(ready_w[1]), .dac_cs(cs_w[1]), .dac_sck(sck_w[1]), .dac_sdi(sdi_w[1]),
        .dac_ld(ld_w[1]), .busy(busy_w[1]), .underrun(und_w[1]), .overrun(ovr_w[1]),
        .clr_flags(clr[1]));

    spi_dac_stream #(.DATA_W(12), .NCH(1), .SCK_HALF(1), .SAMPLE_DIV(40)) u2 (
        .sysclk(sysclk), .rst_n(rstn[2]), .enable(en[2]), .data_in(d2), .data_valid(valid[2]),
        .data_ready(ready_w[2]), .dac_cs(cs_w[2]), .dac_sck(sck_w[2]), .dac_sdi(sdi_w[2]),
        .dac_ld(ld_w[2]), .busy(busy_w[2]), .underrun(und_w[2]), .overrun(ovr_w[2]),
        .clr_flags(clr[2]));

    always #10 sysclk = ~sysclk;

    // SPI monitors: words captured at SCK rise, logged at CS rise.
    logic [15:0] word_log [3][16];
    logic [15:0] sh [3];
    int          word_cnt [3], busy_run [3], busy_len [3];
    int          ld_run [3], ld_len [3], ld_pulses [3], unstable [3];
    logic        sck_p [3], sdi_p [3], cs_p [3], ld_p [3];

    always @(negedge sysclk) begin
        for (int i = 0; i < 3; i++) begin
            if (!cs_w[i] && sck_w[i] && !sck_p[i]) begin
                sh[i] <= {sh[i][14:0], sdi_w[i]};
                if (sdi_w[i] !== sdi_p[i]) unstable[i] <= unstable[i] + 1;
            end
            if (cs_w[i] && cs_p[i] === 1'b0) begin
                word_log[i][word_cnt[i] % 16] <= sh[i];
                word_cnt[i] <= word_cnt[i] + 1;
            end
            if (busy_w[i]) busy_run[i] <= busy_run[i] + 1;
            else begin
                busy_run[i] <= 0;
                if (busy_run[i] > 0) busy_len[i] <= busy_run[i];
            end
            if (!ld_w[i]) begin
                ld_run[i] <= ld_run[i] + 1;
                if (ld_p[i] === 1'b1) ld_pulses[i] <= ld_pulses[i] + 1;
            end else begin
                ld_run[i] <= 0;
                if (ld_run[i] > 0) ld_len[i] <= ld_run[i];
            end
            sck_p[i] <= sck_w[i];
            sdi_p[i] <= sdi_w[i];
            cs_p[i]  <= cs_w[i];
            ld_p[i]  <= ld_w[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input int idx, input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (busy_w[idx] !== lvl && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        chk(tag, 32'(busy_w[idx]), 32'(lvl));
    endtask

    task automatic pulse_valid(input int idx);
        @(negedge sysclk);
        valid[idx] = 1'b1;
        @(negedge sysclk);
        valid[idx] = 1'b0;
    endtask

    task automatic pulse_clr(input int idx);
        @(negedge sysclk);
        clr[idx] = 1'b1;
        @(negedge sysclk);
        clr[idx] = 1'b0;
    endtask

    task automatic run_frame(input int idx, input int budget, input string tag);
        wait_busy(idx, 1'b1, budget, {tag, "_start"});
        wait_busy(idx, 1'b0, 300, {tag, "_end"});
        repeat (3) @(negedge sysclk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lp;
        sysclk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; en[i] = 1'b0; valid[i] = 1'b0; clr[i] = 1'b0;
        end
        d0 = 20'd0; d1 = 20'd0; d2 = 12'd0;
        repeat (3) @(negedge sysclk);
        chk("rst_cs",    32'(cs_w[0]),    32'd1);
        chk("rst_sck",   32'(sck_w[0]),   32'd0);
        chk("rst_sdi",   32'(sdi_w[0]),   32'd0);
        chk("rst_ld",    32'(ld_w[0]),    32'd1);
        chk("rst_busy",  32'(busy_w[0]),  32'd0);
        chk("rst_ready", 32'(ready_w[0]), 32'd1);
        chk("rst_und",   32'(und_w[0]),   32'd0);
        chk("rst_ovr",   32'(ovr_w[0]),   32'd0);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

        // Full-scale ch1, zero ch0.
        d0 = {10'h3FF, 10'h000};
        pulse_valid(0);
        chk("t1_ready_low", 32'(ready_w[0]), 32'd0);
        base = word_cnt[0]; lp = ld_pulses[0];
        en[0] = 1'b1;
        run_frame(0, 6000, "t1");
        chk("t1_word0",  32'(word_log[0][base % 16]),       32'h3000);
        chk("t1_word1",  32'(word_log[0][(base + 1) % 16]), 32'hBFFC);
        chk("t1_busy",   busy_len[0],                       138);
        chk("t1_ldcnt",  ld_pulses[0] - lp,                 1);
        chk("t1_ldlen",  ld_len[0],                         2);
        chk("t1_ready",  32'(ready_w[0]),                   32'd1);
        chk("t1_und",    32'(und_w[0]),                     32'd0);
        chk("t1_ovr",    32'(ovr_w[0]),                     32'd0);

        // One load, then an underrun tick repeats the same words.
        d0 = {10'h155, 10'h155};
        pulse_valid(0);
        base = word_cnt[0];
        run_frame(0, 6000, "t2a");
        chk("t2a_word0", 32'(word_log[0][base % 16]),       32'h3554);
        chk("t2a_word1", 32'(word_log[0][(base + 1) % 16]), 32'hB554);
        chk("t2a_und",   32'(und_w[0]),                     32'd0);
        base = word_cnt[0];
        run_frame(0, 6000, "t2b");
        chk("t2b_word0", 32'(word_log[0][base % 16]),       32'h3554);
        chk("t2b_word1", 32'(word_log[0][(base + 1) % 16]), 32'hB554);
        chk("t2b_und",   32'(und_w[0]),                     32'd1);
        chk("t2b_ready", 32'(ready_w[0]),                   32'd1);
        pulse_clr(0);
        chk("t2_clr_und", 32'(und_w[0]), 32'd0);

        // Reset during bit 7 of channel 0.
        wait_busy(0, 1'b1, 6000, "t4_start");
        repeat (30) @(negedge sysclk);
        chk("t4_mid_cs",  32'(cs_w[0]),  32'd0);
        chk("t4_mid_sck", 32'(sck_w[0]), 32'd1);
        rstn[0] = 1'b0;
        #1;
        chk("t4_rst_cs",   32'(cs_w[0]),   32'd1);
        chk("t4_rst_sck",  32'(sck_w[0]),  32'd0);
        chk("t4_rst_sdi",  32'(sdi_w[0]),  32'd0);
        chk("t4_rst_ld",   32'(ld_w[0]),   32'd1);
        chk("t4_rst_busy", 32'(busy_w[0]), 32'd0);
        @(negedge sysclk);
        rstn[0] = 1'b1;
        chk("t4_rst_und",  32'(und_w[0]), 32'd0);
        d0 = {10'h2AA, 10'h0F0};
        pulse_valid(0);
        base = word_cnt[0]; lp = ld_pulses[0];
        run_frame(0, 6000, "t4");
        chk("t4_word0", 32'(word_log[0][base % 16]),       32'h33C0);
        chk("t4_word1", 32'(word_log[0][(base + 1) % 16]), 32'hBAA8);
        chk("t4_busy",  busy_len[0],                       138);
        chk("t4_ldcnt", ld_pulses[0] - lp,                 1);

        // Valid arriving in the tick cycle with the holding register empty.
        wait_busy(0, 1'b1, 6000, "t6_prev");
        repeat (200) @(negedge sysclk);
        clr[0] = 1'b1;
        @(negedge sysclk);
        clr[0] = 1'b0;
        repeat (4798) @(negedge sysclk);
        chk("t6_ready_pre", 32'(ready_w[0]), 32'd1);
        chk("t6_idle_pre",  32'(busy_w[0]),  32'd0);
        base = word_cnt[0];
        d0 = {10'h001, 10'h3FE};
        valid[0] = 1'b1;
        @(negedge sysclk);
        valid[0] = 1'b0;
        chk("t6_busy",  32'(busy_w[0]),  32'd1);
        chk("t6_ready", 32'(ready_w[0]), 32'd1);
        wait_busy(0, 1'b0, 300, "t6_end");
        repeat (3) @(negedge sysclk);
        chk("t6_word0", 32'(word_log[0][base % 16]),       32'h3FF8);
        chk("t6_word1", 32'(word_log[0][(base + 1) % 16]), 32'hB004);
        chk("t6_und",   32'(und_w[0]),                     32'd0);
        en[0] = 1'b0;

        // Tick period shorter than a frame.
        d1 = {10'h100, 10'h080};
        pulse_valid(1);
        base = word_cnt[1];
        en[1] = 1'b1;
        run_frame(1, 300, "t3");
        en[1] = 1'b0;
        chk("t3_ovr",   32'(ovr_w[1]),                     32'd1);
        chk("t3_busy",  busy_len[1],                       138);
        chk("t3_nword", word_cnt[1] - base,                2);
        chk("t3_word0", 32'(word_log[1][base % 16]),       32'h3200);
        chk("t3_word1", 32'(word_log[1][(base + 1) % 16]), 32'hB400);
        pulse_clr(1);
        chk("t3_clr_ovr", 32'(ovr_w[1]), 32'd0);
        repeat (200) @(negedge sysclk);
        chk("t3_quiet", word_cnt[1] - base, 2);

        // 12-bit single channel, one-cycle SCK half period.
        d2 = 12'hABC;
        pulse_valid(2);
        base = word_cnt[2];
        en[2] = 1'b1;
        run_frame(2, 100, "t5");
        en[2] = 1'b0;
        chk("t5_word",   32'(word_log[2][base % 16]), 32'h3ABC);
        chk("t5_nword",  word_cnt[2] - base,          1);
        chk("t5_busy",   busy_len[2],                 35);
        chk("t5_ldlen",  ld_len[2],                   1);
        chk("t5_stable", unstable[2],                 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
